mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_map_pkg.sv | 23 ++
 rtl/mem_region_check.sv | 21 ++
 rtl/mem_bus_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Memory-map bounds and controller state encoding shared by the bus
// controller and the mem_space model it drives.
package mem_map_pkg;

  localparam logic [15:0] MM_SFR_END   = 16'h0010;
  localparam logic [15:0] MM_PER8_END  = 16'h0100;
  localparam logic [15:0] MM_PER16_END = 16'h0200;
  localparam logic [15:0] MM_RAM_END   = 16'h0400;
  localparam logic [15:0] MM_ROM_BASE  = 16'hC000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  // Word accesses are forced onto an even address; byte accesses pass through.
  function automatic logic [15:0] bus_addr(input logic [15:0] addr, input logic bw);
    return bw ? addr : {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_region_check.sv
// Address decoder: flags accesses into the unused hole, and writes to ROM.
module mem_region_check
  import mem_map_pkg::*;
#(
  parameter logic [15:0] UB_RAM    = MM_RAM_END,
  parameter logic [15:0] UB_UNUSED = MM_ROM_BASE
) (
  input  logic [15:0] addr,
  input  logic        we,
  output logic        fault
);

  logic in_hole;
  logic in_rom;

  // ROM runs up to and including 'hFFFF, so the upper bound is open.
  assign in_hole = (addr >= UB_RAM) && (addr < UB_UNUSED);
  assign in_rom  = (addr >= UB_UNUSED);
  assign fault   = in_hole || (we && in_rom);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding CPU-to-memory bus controller: one request is taken,
// driven onto the memory bus for one cycle, then answered and handshaken.
module mem_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter logic [15:0] UB_RAM    = MM_RAM_END,
  parameter logic [15:0] UB_UNUSED = MM_ROM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_we,
  input  logic        req_bw,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [7:0]  fault_count,
  output logic [15:0] MAB,
  output logic [15:0] MDB_wr,
  output logic        MW,
  output logic        BW,
  input  logic [15:0] MDB_rd
);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [15:0] rdata_reg;
  logic        we_reg;
  logic        bw_reg;
  logic        rsp_fault_reg;
  logic [7:0]  fault_count_reg;
  logic        fault;
  logic        accept;

  mem_region_check #(
    .UB_RAM    (UB_RAM),
    .UB_UNUSED (UB_UNUSED)
  ) u_region (
    .addr  (addr_reg),
    .we    (we_reg),
    .fault (fault)
  );

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = req_we ? ST_WR : ST_RD;
      ST_RD:   state_next = ST_RSP;
      ST_WR:   state_next = ST_RSP;
      ST_RSP:  if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Every bus and response output is a function of state, so a reset edge
  // that returns to IDLE drops MW and the response in the same cycle.
  always_comb begin
    req_ready   = (state_reg == ST_IDLE) && !rst;
    MAB         = 16'h0000;
    MDB_wr      = 16'h0000;
    MW          = 1'b0;
    BW          = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = 16'h0000;
    rsp_fault   = 1'b0;
    fault_count = fault_count_reg;
    case (state_reg)
      ST_RD: begin
        MAB = bus_addr(addr_reg, bw_reg);
        BW  = bw_reg;
      end
      ST_WR: begin
        MAB    = bus_addr(addr_reg, bw_reg);
        BW     = bw_reg;
        MW     = !fault;
        MDB_wr = bw_reg ? {wdata_reg[7:0], wdata_reg[7:0]} : wdata_reg;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_reg;
        rsp_fault = rsp_fault_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg        <= 16'h0000;
      wdata_reg       <= 16'h0000;
      we_reg          <= 1'b0;
      bw_reg          <= 1'b0;
      rdata_reg       <= 16'h0000;
      rsp_fault_reg   <= 1'b0;
      fault_count_reg <= 8'h00;
    end else begin
      if (accept) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        we_reg    <= req_we;
        bw_reg    <= req_bw;
      end
      if (state_reg == ST_RD) begin
        if (fault) begin
          rdata_reg <= 16'h0000;
        end else if (bw_reg) begin
          rdata_reg <= {8'h00, MDB_rd[7:0]};
        end else begin
          rdata_reg <= MDB_rd;
        end
      end else if (state_reg == ST_WR) begin
        rdata_reg <= 16'h0000;
      end
      if ((state_reg == ST_RD) || (state_reg == ST_WR)) begin
        rsp_fault_reg <= fault;
        if (fault && (fault_count_reg != 8'hFF)) begin
          fault_count_reg <= fault_count_reg + 8'h01;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: byte-addressed memory environment, a transaction
// level reference model, directed corner cases and randomized traffic.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_we;
  logic        req_bw;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_fault;
  logic [7:0]  fault_count;
  logic [15:0] MAB;
  logic [15:0] MDB_wr;
  logic        MW;
  logic        BW;
  logic [15:0] MDB_rd;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_bw(req_bw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .fault_count(fault_count),
    .MAB(MAB), .MDB_wr(MDB_wr), .MW(MW), .BW(BW), .MDB_rd(MDB_rd)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int txn_no = 0;

  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
  endfunction

  // Environment memory: byte lanes, byte reads returned on the low lane.
  logic [7:0] bmem [0:65535];
  logic       mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 65536; i++) bmem[i] <= pat(i);
      mem_loaded <= 1'b1;
    end else if (MW) begin
      if (BW) begin
        bmem[MAB] <= MDB_wr[7:0];
      end else begin
        bmem[{MAB[15:1], 1'b0}] <= MDB_wr[7:0];
        bmem[{MAB[15:1], 1'b1}] <= MDB_wr[15:8];
      end
    end
  end
  assign MDB_rd = BW ? {8'h00, bmem[MAB]}
                     : {bmem[{MAB[15:1], 1'b1}], bmem[{MAB[15:1], 1'b0}]};

  // Reference model state
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  exp_fc = 8'h00;
  logic [15:0] last_rdata, last_mab, last_wr;
  logic        last_fault;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus_idle(input string tag);
    chk16({tag, "_mab"}, MAB, 16'h0000);
    chk16({tag, "_mdbwr"}, MDB_wr, 16'h0000);
    chk1({tag, "_mw"}, MW, 1'b0);
    chk1({tag, "_bw"}, BW, 1'b0);
  endtask

  // Called one time unit after an edge with the DUT idle; returns in the same phase.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] wd, input logic we,
                        input logic bw, input int dly);
    logic        f;
    logic [15:0] e_mab, e_wr, e_rd;
    f     = ((a >= 16'h0400) && (a < 16'hC000)) || (we && (a >= 16'hC000));
    e_mab = bw ? a : (a & 16'hFFFE);
    e_wr  = bw ? {wd[7:0], wd[7:0]} : wd;
    if (we || f)  e_rd = 16'h0000;
    else if (bw)  e_rd = {8'h00, ref_mem[a]};
    else          e_rd = {ref_mem[a | 16'h0001], ref_mem[a & 16'hFFFE]};
    last_rdata = e_rd; last_mab = e_mab; last_wr = e_wr; last_fault = f;

    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = we; req_bw = bw;
    rsp_ready = 1'b0;
    step();
    chk16("access_mab", MAB, e_mab);
    chk1("access_bw", BW, bw);
    chk1("access_mw", MW, we && !f);
    chk16("access_mdbwr", MDB_wr, we ? e_wr : 16'h0000);
    chk1("access_rsp_valid", rsp_valid, 1'b0);
    chk1("access_req_ready", req_ready, 1'b0);
    // Request stays asserted with junk to show nothing is queued.
    req_addr = 16'($urandom); req_wdata = 16'($urandom);
    req_we = 1'($urandom); req_bw = 1'($urandom);
    step();
    if (we && !f) begin
      if (bw) ref_mem[a] = wd[7:0];
      else begin
        ref_mem[a & 16'hFFFE] = wd[7:0];
        ref_mem[a | 16'h0001] = wd[15:8];
      end
    end
    if (f && exp_fc != 8'hFF) exp_fc = exp_fc + 8'h01;
    for (int k = 0; k <= dly; k++) begin
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk16("rsp_rdata", rsp_rdata, e_rd);
      chk1("rsp_fault", rsp_fault, f);
      chk16("fault_count", {8'h00, fault_count}, {8'h00, exp_fc});
      chk1("rsp_req_ready", req_ready, 1'b0);
      chk_bus_idle("rsp");
      if (k < dly) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk1("done_rsp_valid", rsp_valid, 1'b0);
    chk1("done_req_ready", req_ready, 1'b1);
    chk16("done_fault_count", {8'h00, fault_count}, {8'h00, exp_fc});
    txn_no++;
    $display("[TB] txn %0d addr=%h we=%0d bw=%0d wdata=%h exp_rdata=%h exp_fault=%0d fc=%h",
             txn_no, a, we, bw, wd, e_rd, f, exp_fc);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    step();
    step();
    exp_fc = 8'h00;
    chk_bus_idle("reset");
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk16("reset_rsp_rdata", rsp_rdata, 16'h0000);
    chk1("reset_rsp_fault", rsp_fault, 1'b0);
    chk16("reset_fault_count", {8'h00, fault_count}, 16'h0000);
    chk1("reset_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("post_reset_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    int r;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0; req_we = 1'b0; req_bw = 1'b0;
    #1;
    do_reset();

    // Word write then unaligned word read of the same word
    do_txn(16'h0202, 16'hBEEF, 1'b1, 1'b0, 0);
    chk16("pin_wr_mab", last_mab, 16'h0202);
    do_txn(16'h0203, 16'h0000, 1'b0, 1'b0, 0);
    chk16("pin_rd_beef", last_rdata, 16'hBEEF);

    // Byte write replicates the low byte; byte read zero-extends
    do_txn(16'h0205, 16'h12A5, 1'b1, 1'b1, 1);
    chk16("pin_byte_mdbwr", last_wr, 16'hA5A5);
    chk16("pin_byte_mab", last_mab, 16'h0205);
    do_txn(16'h0205, 16'h0000, 1'b0, 1'b1, 0);
    chk16("pin_byte_rd", last_rdata, 16'h00A5);

    // Faulted read of the hole and write to ROM
    do_txn(16'h0400, 16'h0000, 1'b0, 1'b0, 0);
    do_txn(16'hC000, 16'h5555, 1'b1, 1'b0, 0);
    chk16("pin_fc_two", {8'h00, exp_fc}, 16'h0002);

    // Long response stall, then the address-map boundaries
    do_txn(16'h0010, 16'h0000, 1'b0, 1'b0, 5);
    do_txn(16'h03FF, 16'h0077, 1'b1, 1'b1, 0);
    do_txn(16'h03FF, 16'h0000, 1'b0, 1'b1, 0);
    chk16("pin_03ff", last_rdata, 16'h0077);
    do_txn(16'hBFFF, 16'h0000, 1'b0, 1'b1, 0);
    chk1("pin_bfff_fault", last_fault, 1'b1);
    do_txn(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
    chk1("pin_ffff_rd_ok", last_fault, 1'b0);
    do_txn(16'hFFFF, 16'h1234, 1'b1, 1'b1, 0);
    chk1("pin_ffff_wr_fault", last_fault, 1'b1);

    // Reset during WR: MW drops at the reset edge and no response appears.
    // The write still lands because memory sees MW at that edge.
    req_valid = 1'b1; req_addr = 16'h0100; req_wdata = 16'hCAFE;
    req_we = 1'b1; req_bw = 1'b0;
    step();
    chk1("abort_mw_before", MW, 1'b1);
    rst = 1'b1; req_valid = 1'b0;
    ref_mem[16'h0100] = 8'hFE; ref_mem[16'h0101] = 8'hCA;
    step();
    exp_fc = 8'h00;
    chk_bus_idle("abort");
    chk1("abort_rsp_valid", rsp_valid, 1'b0);
    chk16("abort_rsp_rdata", rsp_rdata, 16'h0000);
    chk1("abort_rsp_fault", rsp_fault, 1'b0);
    chk16("abort_fc", {8'h00, fault_count}, 16'h0000);
    step();
    chk1("abort_rsp_valid2", rsp_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk1("abort_req_ready", req_ready, 1'b1);
    do_txn(16'h0101, 16'h0000, 1'b0, 1'b0, 0);

    // Randomized traffic across RAM, hole and ROM
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = 16'($urandom_range(0, 16'h03FF));
      else if (r < 8) a = 16'($urandom_range(16'h0400, 16'hBFFF));
      else            a = 16'($urandom_range(16'hC000, 16'hFFFF));
      do_txn(a, 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    // Fault counter saturation
    for (int n = 0; n < 256; n++) begin
      do_txn(16'($urandom_range(16'h0400, 16'hBFFF)), 16'h0000, 1'b0, 1'($urandom), 0);
    end
    chk16("pin_fc_sat", {8'h00, exp_fc}, 16'h00FF);
    chk16("final_fc", {8'h00, fault_count}, 16'h00FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
